// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: 4-bit unsigned sequential restoring divider.
// One restoring step per clock in CALC (4 steps), one-cycle done pulse in DONE.
// Optional feature macro: DIV_DBZ_EN. When it is defined, a divide by zero skips
// CALC, completes in one cycle and raises the dbz flag.
module seq_restoring_divider (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [3:0] quotient,
    output logic [3:0] remainder
`ifdef DIV_DBZ_EN
    ,
    output logic       dbz
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Restoring step: shift the next dividend bit into the partial remainder,
    // subtract the divisor, and keep the difference only if it did not borrow.
    // Returns {new_partial_remainder[4:0], new_q[3:0]}.
    function automatic logic [8:0] restore_step(input logic [4:0] r,
                                                input logic [3:0] q,
                                                input logic [3:0] d);
        logic [4:0] s;
        logic [5:0] t;
        s = {r[3:0], q[3]};
        t = {1'b0, s} - {2'b00, d};
        if (t[5]) begin
            restore_step = {s, q[2:0], 1'b0};
        end else begin
            restore_step = {t[4:0], q[2:0], 1'b1};
        end
    endfunction

    state_t     state_r, state_s;
    logic [3:0] q_r, q_s;
    logic [3:0] d_r, d_s;
    logic [4:0] r_r, r_s;
    logic [1:0] cnt_r, cnt_s;
    logic [3:0] quotient_r, quotient_s;
    logic [3:0] remainder_r, remainder_s;
    logic       done_r, done_s;
    logic       busy_r, busy_s;
    logic [8:0] step_s;
`ifdef DIV_DBZ_EN
    logic       dbz_r, dbz_s;
`endif

    // Combinational restoring step on the captured operands.
    always_comb begin
        step_s = restore_step(r_r, q_r, d_r);
    end

    // Next-state and next-datapath logic; every register holds by default.
    always_comb begin
        state_s     = state_r;
        q_s         = q_r;
        d_s         = d_r;
        r_s         = r_r;
        cnt_s       = cnt_r;
        quotient_s  = quotient_r;
        remainder_s = remainder_r;
        done_s      = 1'b0;
`ifdef DIV_DBZ_EN
        dbz_s       = dbz_r;
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    q_s     = dividend;
                    d_s     = divisor;
                    r_s     = 5'd0;
                    cnt_s   = 2'd0;
                    state_s = CALC;
`ifdef DIV_DBZ_EN
                    if (divisor == 4'd0) begin
                        state_s     = DONE;
                        quotient_s  = 4'hF;
                        remainder_s = dividend;
                        dbz_s       = 1'b1;
                        done_s      = 1'b1;
                    end else begin
                        dbz_s       = 1'b0;
                    end
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                r_s = step_s[8:4];
                q_s = step_s[3:0];
                if (cnt_r == 2'd3) begin
                    quotient_s  = step_s[3:0];
                    remainder_s = step_s[7:4];
                    done_s      = 1'b1;
                    state_s     = DONE;
                end else begin
                    cnt_s       = cnt_r + 2'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            q_r         <= 4'd0;
            d_r         <= 4'd0;
            r_r         <= 5'd0;
            cnt_r       <= 2'd0;
            quotient_r  <= 4'd0;
            remainder_r <= 4'd0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
`ifdef DIV_DBZ_EN
            dbz_r       <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            q_r         <= q_s;
            d_r         <= d_s;
            r_r         <= r_s;
            cnt_r       <= cnt_s;
            quotient_r  <= quotient_s;
            remainder_r <= remainder_s;
            done_r      <= done_s;
            busy_r      <= busy_s;
`ifdef DIV_DBZ_EN
            dbz_r       <= dbz_s;
`endif
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;
`ifdef DIV_DBZ_EN
    assign dbz       = dbz_r;
`endif

endmodule
